// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle, then a single fix-up cycle applies signs and writes HI/LO.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic             ReadSel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_mag_reg;
    logic [WIDTH-1:0]   b_mag_reg;
    logic [WIDTH-1:0]   orig_a_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [CW-1:0]      count_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               div_zero_reg;
    logic               is_div_reg;
    logic               busy_reg;
    logic               done_reg;

    // Op[0] set means unsigned: operands are taken raw, never negated.
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign sign_a = ~Op[0] & IN_A[WIDTH-1];
    assign sign_b = ~Op[0] & IN_B[WIDTH-1];
    assign abs_a  = sign_a ? -IN_A : IN_A;
    assign abs_b  = sign_b ? -IN_B : IN_B;

    // Shift-add: low half of prod_reg holds the remaining multiplier bits.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + (prod_reg[0] ? {1'b0, a_mag_reg} : {(WIDTH+1){1'b0}});

    // Restoring division: quo_reg starts as the dividend and fills with quotient bits.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_fits;
    assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_reg};
    assign div_fits  = ~div_diff[WIDTH+1];

    logic last_iter;
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [2*WIDTH-1:0] prod_signed;

    always_comb begin
        prod_signed = sign_q_reg ? -prod_reg : prod_reg;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (is_div_reg) begin
            if (div_zero_reg) begin
                fix_hi = orig_a_reg;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = sign_r_reg ? -rem_reg : rem_reg;
                fix_lo = sign_q_reg ? -quo_reg : quo_reg;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            a_mag_reg    <= '0;
            b_mag_reg    <= '0;
            orig_a_reg   <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            prod_reg     <= '0;
            count_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            is_div_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        a_mag_reg    <= abs_a;
                        b_mag_reg    <= abs_b;
                        orig_a_reg   <= IN_A;
                        sign_q_reg   <= sign_a ^ sign_b;
                        sign_r_reg   <= sign_a;
                        div_zero_reg <= Op[1] && (IN_B == '0);
                        is_div_reg   <= Op[1];
                        count_reg    <= '0;
                        prod_reg     <= {{WIDTH{1'b0}}, abs_b};
                        quo_reg      <= abs_a;
                        rem_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= Op[1] ? DIV : MUL;
                    end else begin
                        // A same-cycle Start takes priority, so moves only land here.
                        if (HiWrite) hi_reg <= IN_A;
                        if (LoWrite) lo_reg <= IN_A;
                    end
                end
                MUL: begin
                    prod_reg  <= {mul_sum, prod_reg[WIDTH-1:1]};
                    count_reg <= count_reg + CW'(1);
                    if (last_iter) state_reg <= FIX;
                end
                DIV: begin
                    if (div_fits) begin
                        rem_reg <= div_diff[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= div_shift[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    count_reg <= count_reg + CW'(1);
                    if (last_iter) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;
    assign Out  = ReadSel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed spec cases plus random
// operations checked against a 64-bit arithmetic reference model.
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Start;
    logic [1:0]    Op;
    logic [W-1:0]  IN_A;
    logic [W-1:0]  IN_B;
    logic          HiWrite;
    logic          LoWrite;
    logic          ReadSel;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;
    logic [W-1:0]  Out;

    int checks = 0;
    int errors = 0;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .Op(Op),
        .IN_A(IN_A), .IN_B(IN_B), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .ReadSel(ReadSel), .Busy(Busy), .Done(Done),
        .HI(HI), .LO(LO), .Out(Out)
    );

    always #5 CLK = ~CLK;

    // Reference: MIPS semantics computed with 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); lo = p[31:0];
                    p = 64'(r); hi = p[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start = 1'b1; Op = op; IN_A = a; IN_B = b;
        @(negedge CLK);
        Start = 1'b0; IN_A = $urandom; IN_B = $urandom;
    endtask

    // Returns at the negedge where Done is seen (or after the cycle budget).
    task automatic wait_done(output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin
                done_cnt++;
                break;
            end
            if (Busy) busy_cnt++;
            @(negedge CLK);
        end
    endtask

    task automatic exec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output int done_cnt);
        start_op(op, a, b);
        wait_done(busy_cnt, done_cnt);
    endtask

    task automatic test_reset();
        RESET = 1'b1; Start = 1'b0; Op = 2'b00; IN_A = '0; IN_B = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; ReadSel = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
        ReadSel = 1'b1; #1;
        checks++; if (Out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", Out); end
        RESET = 1'b0;
        $display("reset: Busy=%b Done=%b HI=%h LO=%h", Busy, Done, HI, LO);
    endtask

    task automatic test_multu();
        int bc, dc;
        exec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        checks++; if (dc !== 1) begin errors++; $display("FAIL multu_done got %0d want 1", dc); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", HI); end
        checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", LO); end
        ReadSel = 1'b1; #1;
        checks++; if (Out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_out_hi got %h want fffffffe", Out); end
        ReadSel = 1'b0; #1;
        checks++; if (Out !== 32'h0000_0001) begin errors++; $display("FAIL multu_out_lo got %h want 00000001", Out); end
        @(negedge CLK);
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", Done); end
        $display("MULTU ffffffff*ffffffff: HI=%h LO=%h busy=%0d", HI, LO, bc);
    endtask

    task automatic test_mult();
        logic [31:0] ta [2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] tb [2] = '{32'h0000_0007, 32'h8000_0000};
        logic [31:0] eh [2] = '{32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] el [2] = '{32'hFFFF_FFEB, 32'h0000_0000};
        int bc, dc;
        for (int i = 0; i < 2; i++) begin
            exec(2'b00, ta[i], tb[i], bc, dc);
            checks++; if (dc !== 1 || bc !== 33) begin errors++; $display("FAIL mult_timing[%0d] got done=%0d busy=%0d want 1/33", i, dc, bc); end
            checks++; if (HI !== eh[i]) begin errors++; $display("FAIL mult_hi[%0d] got %h want %h", i, HI, eh[i]); end
            checks++; if (LO !== el[i]) begin errors++; $display("FAIL mult_lo[%0d] got %h want %h", i, LO, el[i]); end
            $display("MULT %h*%h: HI=%h LO=%h", ta[i], tb[i], HI, LO);
        end
    endtask

    task automatic test_div();
        logic [1:0]  to [3] = '{2'b10, 2'b11, 2'b10};
        logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'h2, 32'h2, 32'hFFFF_FFFF};
        logic [31:0] eh [3] = '{32'hFFFF_FFFF, 32'h1, 32'h0};
        logic [31:0] el [3] = '{32'hFFFF_FFFD, 32'h3, 32'h8000_0000};
        int bc, dc;
        for (int i = 0; i < 3; i++) begin
            exec(to[i], ta[i], tb[i], bc, dc);
            checks++; if (dc !== 1 || bc !== 33) begin errors++; $display("FAIL div_timing[%0d] got done=%0d busy=%0d want 1/33", i, dc, bc); end
            checks++; if (HI !== eh[i]) begin errors++; $display("FAIL div_hi[%0d] got %h want %h", i, HI, eh[i]); end
            checks++; if (LO !== el[i]) begin errors++; $display("FAIL div_lo[%0d] got %h want %h", i, LO, el[i]); end
            $display("DIV op=%b %h/%h: HI=%h LO=%h", to[i], ta[i], tb[i], HI, LO);
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  to [2] = '{2'b11, 2'b10};
        logic [31:0] ta [2] = '{32'h5, 32'hFFFF_FFFB};
        int bc, dc;
        for (int i = 0; i < 2; i++) begin
            exec(to[i], ta[i], 32'h0, bc, dc);
            checks++; if (dc !== 1 || bc !== 33) begin errors++; $display("FAIL divzero_timing[%0d] got done=%0d busy=%0d want 1/33", i, dc, bc); end
            checks++; if (HI !== ta[i]) begin errors++; $display("FAIL divzero_hi[%0d] got %h want %h", i, HI, ta[i]); end
            checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo[%0d] got %h want ffffffff", i, LO); end
            $display("DIV0 op=%b %h/0: HI=%h LO=%h", to[i], ta[i], HI, LO);
        end
    endtask

    task automatic test_ignored();
        int bc, dc;
        @(negedge CLK);
        HiWrite = 1'b1; LoWrite = 1'b1; IN_A = 32'h5A5A_1234;
        @(negedge CLK);
        HiWrite = 1'b0; LoWrite = 1'b0;
        start_op(2'b11, 32'd100, 32'd7);
        repeat (3) @(negedge CLK);
        checks++; if (HI !== 32'h5A5A_1234 || LO !== 32'h5A5A_1234) begin errors++; $display("FAIL hold_during_op got HI=%h LO=%h want 5a5a1234", HI, LO); end
        Start = 1'b1; Op = 2'b01; IN_A = 32'd2; IN_B = 32'd2; HiWrite = 1'b1; LoWrite = 1'b1;
        @(negedge CLK);
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        checks++; if (HI !== 32'h5A5A_1234 || Busy !== 1'b1) begin errors++; $display("FAIL hiwrite_busy got HI=%h Busy=%b want 5a5a1234/1", HI, Busy); end
        wait_done(bc, dc);
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignored_done got %0d want 1", dc); end
        checks++; if (HI !== 32'd2 || LO !== 32'd14) begin errors++; $display("FAIL ignored_result got HI=%h LO=%h want 2/e", HI, LO); end
        dc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (Busy || Done) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL start_not_queued got %0d active cycles want 0", dc); end
        $display("ignored start/write during DIVU 100/7: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_reset_mid();
        int bc, dc;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge CLK);
        RESET = 1'b1; #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++; $display("FAIL reset_mid got Busy=%b Done=%b HI=%h LO=%h want 0", Busy, Done, HI, LO);
        end
        @(negedge CLK);
        RESET = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done || Busy) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL reset_no_done got %0d active cycles want 0", dc); end
        exec(2'b01, 32'd6, 32'd7, bc, dc);
        checks++; if (dc !== 1 || bc !== 33 || LO !== 32'd42 || HI !== 32'd0) begin
            errors++; $display("FAIL after_reset_multu got done=%0d busy=%0d HI=%h LO=%h want 1/33/0/2a", dc, bc, HI, LO);
        end
        $display("reset mid-op then MULTU 6*7: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_mthi_mtlo();
        int bc, dc;
        @(negedge CLK);
        HiWrite = 1'b1; IN_A = 32'h1234_5678; ReadSel = 1'b1; #1;
        checks++; if (Out !== 32'h0) begin errors++; $display("FAIL mthi_early got %h want 0", Out); end
        @(negedge CLK);
        HiWrite = 1'b0;
        checks++; if (Out !== 32'h1234_5678) begin errors++; $display("FAIL mthi_out got %h want 12345678", Out); end
        LoWrite = 1'b1; IN_A = 32'hCAFE_F00D; ReadSel = 1'b0;
        @(negedge CLK);
        LoWrite = 1'b0;
        checks++; if (Out !== 32'hCAFE_F00D || HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_out got Out=%h HI=%h want cafef00d/12345678", Out, HI); end
        Start = 1'b1; Op = 2'b01; IN_A = 32'd3; IN_B = 32'd4; HiWrite = 1'b1;
        @(negedge CLK);
        Start = 1'b0; HiWrite = 1'b0;
        checks++; if (HI !== 32'h1234_5678 || Busy !== 1'b1) begin errors++; $display("FAIL start_beats_mthi got HI=%h Busy=%b want 12345678/1", HI, Busy); end
        wait_done(bc, dc);
        checks++; if (dc !== 1 || bc !== 33 || HI !== 32'd0 || LO !== 32'd12) begin
            errors++; $display("FAIL start_mthi_result got done=%0d busy=%0d HI=%h LO=%h want 1/33/0/c", dc, bc, HI, LO);
        end
        $display("MTHI/MTLO + Out mux: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, eh, el, d;
        logic        hw, lw;
        int bc, dc;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            model(op, a, b, eh, el);
            exec(op, a, b, bc, dc);
            checks++; if (dc !== 1 || bc !== 33 || HI !== eh || LO !== el) begin
                errors++; $display("FAIL rand_op[%0d] op=%b a=%h b=%h got HI=%h LO=%h done=%0d busy=%0d want HI=%h LO=%h", i, op, a, b, HI, LO, dc, bc, eh, el);
            end
            $display("rand op=%b a=%h b=%h HI=%h LO=%h", op, a, b, HI, LO);
            hw = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            d = $urandom;
            @(negedge CLK);
            HiWrite = hw; LoWrite = lw; IN_A = d;
            if (hw) eh = d;
            if (lw) el = d;
            @(negedge CLK);
            HiWrite = 1'b0; LoWrite = 1'b0;
            ReadSel = 1'b1; #1;
            checks++; if (Out !== eh) begin errors++; $display("FAIL rand_move_hi[%0d] got %h want %h", i, Out, eh); end
            ReadSel = 1'b0; #1;
            checks++; if (Out !== el) begin errors++; $display("FAIL rand_move_lo[%0d] got %h want %h", i, Out, el); end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_reset_mid();
        test_mthi_mtlo();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over multiple cycles, stalling the core through Busy. It also services MTHI/MTLO writes. Its Out port feeds the write-back 2:1 mux that selects between the ALU result and the HI/LO result (MFHI/MFLO).

## Interface
- WIDTH, default 32: operand, HI and LO width.
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  reset; asynchronous, active-high.
- Start  input  1  begin the operation encoded on Op. Sampled only while Busy=0.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- IN_A  input  WIDTH  rs operand: multiplicand/dividend, and the data for MTHI/MTLO.
- IN_B  input  WIDTH  rt operand: multiplier/divisor.
- HiWrite  input  1  MTHI: HI <= IN_A.
- LoWrite  input  1  MTLO: LO <= IN_A.
- ReadSel  input  1  0 selects LO onto Out, 1 selects HI.
- Busy  output  1  operation in progress; the core stalls on it.
- Done  output  1  one-cycle pulse when HI/LO receive a new result.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- Out  output  WIDTH  combinational: ReadSel ? HI : LO.

## Operation
- States:
  - IDLE: wait for Start.
  - MUL: shift-add, 1 bit per cycle.
  - DIV: restoring division, 1 bit per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE + Start:
  - Latch operand magnitudes. Signed ops use the two's-complement absolute value; unsigned ops take the raw value.
  - Record the quotient/product sign (signA ^ signB) and the remainder sign (signA).
  - Record divide-by-zero (IN_B==0, DIV/DIVU only).
  - Clear the iteration counter. Go to MUL (Op[1]=0) or DIV (Op[1]=1).
- MUL/DIV: exactly WIDTH iterations, then go to FIX.
- Magnitudes are treated as unsigned WIDTH-bit values, so abs(0x80000000)=0x80000000.
- FIX:
  - Multiply: {HI,LO} <= 2*WIDTH-bit product, negated if the sign bit is set.
  - Divide: LO <= quotient, negated if quotient sign is set. HI <= remainder, negated if signA is set.
  - Divide-by-zero overrides: HI <= original IN_A, LO <= all ones, for both DIV and DIVU.
  - Return to IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no special case.
- HiWrite/LoWrite:
  - Honoured only in IDLE with Start=0; both may fire in the same cycle.
  - Ignored while Busy=1.
  - If Start=1 in the same cycle, Start wins and the writes are dropped.
- Start while Busy=1: ignored. It is not queued.
- During an operation, HI/LO (and Out) hold their previous values until FIX.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0. Out therefore reads 0.
- RESET asserted mid-operation aborts immediately. HI/LO are cleared and no Done pulse is issued.
- Start sampled on edge E0:
  - Busy=1 from after E0 through after E(WIDTH); iterations on E1..E(WIDTH).
  - FIX on E(WIDTH+1): HI/LO are updated, Busy=0 and Done=1 for exactly one cycle.
  - A new Start is accepted on the edge ending the Done cycle.
- Busy is high for WIDTH+1 cycles; the result is readable on Out in the Done cycle. For WIDTH=32 this is 33 busy cycles.
- MTHI/MTLO: registered; the value is visible on HI/LO/Out the cycle after the write edge.
- Out has no added latency: it is a pure mux of the HI/LO registers.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Busy high for 33 cycles, one Done pulse, new values visible in the Done cycle.
- **MULT:** -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- **DIV/DIVU:** DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- **Divide-by-zero:** DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF, same 33-cycle latency. DIV -5 / 0 -> HI=0xFFFFFFFB, LO=0xFFFFFFFF.
- **Ignored inputs and reset:**
  - Start (MULTU 2×2) issued during an active DIVU: ignored, and the DIVU result is unchanged.
  - HiWrite during Busy: ignored.
  - RESET pulsed at iteration 10: Busy=0, HI=LO=0, no Done; the following MULTU 6×7 gives LO=42.
- **MTHI/MTLO and Out mux:**
  - HiWrite with IN_A=0x12345678 -> next cycle ReadSel=1 gives Out=0x12345678.
  - LoWrite with 0xCAFEF00D -> ReadSel=0 gives Out=0xCAFEF00D.
  - Start plus HiWrite in the same cycle -> HI unchanged until FIX.
